// File: rtl/apu_serial_rx.sv
//------------------------------------------------------------------------------
// Module  : apu_serial_rx
// Brief   : 8N1 UART receiver that turns host bytes into 4-byte register-write
//           frames for the APU sound-generator register file.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module apu_serial_rx #(
  parameter int CLKRATE     = 1_789_773,
  parameter int BAUDRATE    = 9600,
  parameter int GAP_BITS    = 20,
  parameter int LINK_CYCLES = 178_977
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic       o_tx,
  output logic       o_reg_wr,
  output logic [1:0] o_reg_addr,
  output logic [7:0] o_reg_data,
  output logic       o_frame_done,
  output logic       o_frame_err,
  output logic       o_link
);

  localparam int DIVISOR = CLKRATE / BAUDRATE;
  localparam int HALF    = DIVISOR / 2;
  localparam int GAP_MAX = GAP_BITS * DIVISOR;
  localparam int BW      = $clog2(DIVISOR + 1);
  localparam int GW      = $clog2(GAP_MAX + 1);
  localparam int LW      = $clog2(LINK_CYCLES + 1);

  localparam logic [BW-1:0] c_div     = BW'(DIVISOR);
  localparam logic [BW-1:0] c_half    = BW'(HALF);
  localparam logic [BW-1:0] c_bit_one = BW'(1);
  localparam logic [GW-1:0] c_gap_max = GW'(GAP_MAX);
  localparam logic [LW-1:0] c_link    = LW'(LINK_CYCLES);
  localparam logic [LW-1:0] c_lnk_one = LW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_sync1;
  logic            r_rxs;
  logic            r_rxs_d;
  logic [BW-1:0]   r_bit_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic [1:0]      r_idx;
  logic [GW-1:0]   r_gap_cnt;
  logic [LW-1:0]   r_link_cnt;
  logic            r_wr_pend;
  logic            r_reg_wr;
  logic [1:0]      r_reg_addr;
  logic [7:0]      r_reg_data;
  logic            r_frame_done;
  logic            r_frame_err;
  logic            r_link;

  logic w_fall;
  logic w_expire;
  logic w_load_half;
  logic w_load_div;
  logic w_shift_en;
  logic w_stop_ok;
  logic w_stop_bad;

  assign w_fall   = r_rxs_d & ~r_rxs;
  assign w_expire = (r_bit_cnt == c_bit_one);

  // Synchronizer flops reset to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_rxs   <= r_sync1;
      r_rxs_d <= r_rxs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_half = 1'b0;
    w_load_div  = 1'b0;
    w_shift_en  = 1'b0;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt = S_START;
          w_load_half = 1'b1;
        end
      end
      S_START: begin
        if (w_expire) begin
          if (!r_rxs) begin
            w_state_nxt = S_DATA;
            w_load_div  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_expire) begin
          w_shift_en = 1'b1;
          w_load_div = 1'b1;
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_expire) begin
          if (r_rxs) begin
            w_stop_ok   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (r_rxs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit timer: loaded value N expires N cycles later, then idles at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (w_load_half)          r_bit_cnt <= c_half;
      else if (w_load_div)      r_bit_cnt <= c_div;
      else if (r_bit_cnt != '0) r_bit_cnt <= r_bit_cnt - c_bit_one;

      if (w_load_half)     r_bit_idx <= '0;
      else if (w_shift_en) r_bit_idx <= r_bit_idx + 3'd1;

      if (w_shift_en) r_shift <= {r_rxs, r_shift[7:1]};
    end
  end

  // Frame error outranks everything; a saturated gap keeps the index at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt <= '0;
      r_idx     <= '0;
    end else begin
      if (w_stop_ok)
        r_gap_cnt <= '0;
      else if (r_state == S_IDLE && r_gap_cnt != c_gap_max)
        r_gap_cnt <= r_gap_cnt + GW'(1);

      if (w_stop_bad)                 r_idx <= '0;
      else if (r_wr_pend)             r_idx <= r_idx + 2'd1;
      else if (r_gap_cnt == c_gap_max) r_idx <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_pend    <= 1'b0;
      r_reg_wr     <= 1'b0;
      r_reg_addr   <= '0;
      r_reg_data   <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_wr_pend    <= w_stop_ok;
      r_reg_wr     <= r_wr_pend;
      r_frame_done <= r_wr_pend && (r_idx == 2'd3);
      r_frame_err  <= w_stop_bad;
      if (r_wr_pend) begin
        r_reg_addr <= r_idx;
        r_reg_data <= r_shift;
      end
    end
  end

  // Link rises with the write strobe and falls LINK_CYCLES edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_link_cnt <= '0;
      r_link     <= 1'b0;
    end else if (r_wr_pend) begin
      r_link_cnt <= c_link;
      r_link     <= 1'b1;
    end else if (r_link_cnt != '0) begin
      r_link_cnt <= r_link_cnt - c_lnk_one;
      if (r_link_cnt == c_lnk_one) r_link <= 1'b0;
    end
  end

  assign o_tx         = r_rxs;
  assign o_reg_wr     = r_reg_wr;
  assign o_reg_addr   = r_reg_addr;
  assign o_reg_data   = r_reg_data;
  assign o_frame_done = r_frame_done;
  assign o_frame_err  = r_frame_err;
  assign o_link       = r_link;

endmodule

`default_nettype wire

// File: tb/tb_apu_serial_rx.sv
//------------------------------------------------------------------------------
// Module  : tb_apu_serial_rx
// Brief   : Directed scoreboard bench for apu_serial_rx at a scaled baud rate.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_apu_serial_rx;

  localparam int CLKRATE     = 1_600_000;
  localparam int BAUDRATE    = 100_000;
  localparam int GAP_BITS    = 20;
  localparam int LINK_CYCLES = 2000;
  localparam int D           = CLKRATE / BAUDRATE;
  localparam int H           = D / 2;
  localparam int LAT         = 2 + H + 9 * D + 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       o_tx;
  logic       o_reg_wr;
  logic [1:0] o_reg_addr;
  logic [7:0] o_reg_data;
  logic       o_frame_done;
  logic       o_frame_err;
  logic       o_link;

  apu_serial_rx #(
    .CLKRATE    (CLKRATE),
    .BAUDRATE   (BAUDRATE),
    .GAP_BITS   (GAP_BITS),
    .LINK_CYCLES(LINK_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx        (rx),
    .o_tx        (o_tx),
    .o_reg_wr    (o_reg_wr),
    .o_reg_addr  (o_reg_addr),
    .o_reg_data  (o_reg_data),
    .o_frame_done(o_frame_done),
    .o_frame_err (o_frame_err),
    .o_link      (o_link)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    int         t0;
  } wr_t;

  wr_t        sb[$];
  wr_t        mon_e;
  int         cyc         = 0;
  int         checks      = 0;
  int         errors      = 0;
  int         fe_cnt      = 0;
  int         fd_cnt      = 0;
  int         last_wr_cyc = 0;
  int         lat;
  logic [1:0] exp_idx     = 2'd0;
  logic [1:0] rxh         = 2'b11;
  bit         tx_chk      = 1'b0;
  bit         prev_wr     = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rxh <= {rxh[0], rx};
  end

  // Output monitor: pops the scoreboard on every write strobe.
  always @(negedge clk) begin
    if (o_reg_wr) begin
      last_wr_cyc = cyc;
      checks++;
      assert (!prev_wr) else begin
        errors++; $error("FAIL wr_width observed=2+ cycles expected=1 cycle");
      end
      checks++;
      assert (sb.size() != 0) else begin
        errors++; $error("FAIL unexpected_wr observed addr=%0d data=%02h expected=no write", o_reg_addr, o_reg_data);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        lat = cyc - mon_e.t0 - 1;
        checks++;
        assert (o_reg_addr === mon_e.addr) else begin
          errors++; $error("FAIL wr_addr observed=%0d expected=%0d", o_reg_addr, mon_e.addr);
        end
        checks++;
        assert (o_reg_data === mon_e.data) else begin
          errors++; $error("FAIL wr_data observed=%02h expected=%02h", o_reg_data, mon_e.data);
        end
        checks++;
        assert (lat >= LAT - 2 && lat <= LAT + 2) else begin
          errors++; $error("FAIL wr_latency observed=%0d expected=%0d+-2", lat, LAT);
        end
        checks++;
        assert (o_frame_done === (mon_e.addr == 2'd3)) else begin
          errors++; $error("FAIL frame_done_wr observed=%b expected=%b", o_frame_done, (mon_e.addr == 2'd3));
        end
      end
    end else begin
      checks++;
      assert (o_frame_done !== 1'b1) else begin
        errors++; $error("FAIL frame_done_alone observed=1 expected=0");
      end
    end
    if (tx_chk) begin
      checks++;
      assert (o_tx === rxh[1]) else begin
        errors++; $error("FAIL tx_echo observed=%b expected=%b", o_tx, rxh[1]);
      end
    end
    if (o_frame_done) fd_cnt++;
    if (o_frame_err)  fe_cnt++;
    prev_wr = o_reg_wr;
  end

  task automatic check_reset(input string tag);
    checks++;
    assert (o_reg_wr === 1'b0 && o_frame_done === 1'b0 && o_frame_err === 1'b0) else begin
      errors++; $error("FAIL %s_strobes observed=%b%b%b expected=000", tag, o_reg_wr, o_frame_done, o_frame_err);
    end
    checks++;
    assert (o_link === 1'b0) else begin
      errors++; $error("FAIL %s_link observed=%b expected=0", tag, o_link);
    end
    checks++;
    assert (o_reg_addr === 2'd0) else begin
      errors++; $error("FAIL %s_addr observed=%0d expected=0", tag, o_reg_addr);
    end
    checks++;
    assert (o_reg_data === 8'h00) else begin
      errors++; $error("FAIL %s_data observed=%02h expected=00", tag, o_reg_data);
    end
    checks++;
    assert (o_tx === 1'b1) else begin
      errors++; $error("FAIL %s_tx observed=%b expected=1", tag, o_tx);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (D) @(negedge clk);
    end
    rx = stop;
    repeat (D) @(negedge clk);
  endtask

  task automatic tx_byte(input logic [7:0] b);
    wr_t e;
    e.addr = exp_idx;
    e.data = b;
    e.t0   = cyc;
    sb.push_back(e);
    exp_idx = exp_idx + 2'd1;
    send_byte(b, 1'b1);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * D) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20 * D) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++; $error("FAIL %s_drain observed=%0d pending expected=0", tag, sb.size());
    end
  endtask

  initial begin
    int fe_before;
    int n;

    // Reset state
    repeat (4) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    idle_bits(2);

    // Single byte with echo check
    tx_chk = 1'b1;
    tx_byte(8'hA5);
    tx_chk = 1'b0;
    drain("single");
    checks++;
    assert (o_link === 1'b1) else begin
      errors++; $error("FAIL link_after_wr observed=%b expected=1", o_link);
    end

    // Full frame plus one, back-to-back, after a realigning gap
    idle_bits(GAP_BITS + 5);
    exp_idx = 2'd0;
    tx_byte(8'h3F);
    tx_byte(8'h08);
    tx_byte(8'hFD);
    tx_byte(8'h01);
    tx_byte(8'h55);
    drain("frame");
    checks++;
    assert (fd_cnt == 1) else begin
      errors++; $error("FAIL frame_done_count observed=%0d expected=1", fd_cnt);
    end

    // Glitch shorter than half a bit
    idle_bits(GAP_BITS + 5);
    exp_idx   = 2'd0;
    fe_before = fe_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle_bits(3);
    checks++;
    assert (fe_cnt == fe_before) else begin
      errors++; $error("FAIL glitch_err observed=%0d expected=%0d", fe_cnt, fe_before);
    end
    tx_byte(8'h12);
    drain("glitch");

    // Stop-bit error followed by a held-low line
    fe_before = fe_cnt;
    send_byte(8'h77, 1'b0);
    rx = 1'b0;
    repeat (2 * D) @(negedge clk);
    idle_bits(2);
    exp_idx = 2'd0;
    checks++;
    assert (fe_cnt == fe_before + 1) else begin
      errors++; $error("FAIL frame_err_count observed=%0d expected=%0d", fe_cnt - fe_before, 1);
    end
    tx_byte(8'h9C);
    drain("after_err");

    // Gap realignment and link timeout
    tx_byte(8'h01);
    tx_byte(8'h02);
    idle_bits(25);
    exp_idx = 2'd0;
    tx_byte(8'h03);
    drain("gap");
    n = 0;
    while (o_link === 1'b1 && n < LINK_CYCLES + 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (o_link === 1'b0) else begin
      errors++; $error("FAIL link_timeout observed=%b expected=0", o_link);
    end
    checks++;
    assert (cyc - last_wr_cyc == LINK_CYCLES) else begin
      errors++; $error("FAIL link_hold observed=%0d expected=%0d", cyc - last_wr_cyc, LINK_CYCLES);
    end

    // Reset during data bit 4 of 0xF0
    rx = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      repeat (D) @(negedge clk);
    end
    rx = 1'b1;
    repeat (H) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset");
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2 * 10);
    exp_idx = 2'd0;
    tx_byte(8'h0F);
    drain("post_reset");

    idle_bits(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
